// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder for the MEM stage. Accepts
//            one load/store at a time, stalls the pipeline while the access
//            is in flight, and returns a one-cycle done/err response.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int         c_aw        = $clog2(DEPTH);
  localparam logic [3:0] c_wait_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [c_aw+1:0] r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_acc_we;
  logic [c_aw+1:0] w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [3:0]      w_acc_be;
  logic            w_misaligned;
  logic [c_aw-1:0] w_idx;
  logic            w_unused_addr;

  // Address bits above the word index are ignored, so the store wraps
  assign w_unused_addr = &{1'b0, addr_i[31:c_aw+2]};

  // A request is taken only from IDLE and never while reset is asserted
  assign w_accept = rst_n_i && (r_state == S_IDLE) && req_i;
  assign stall_o  = w_accept || (r_state == S_WAIT);

  // With single-cycle latency the access completes straight from the port;
  // otherwise it completes from the captured copy at the end of WAIT
  generate
    if (LATENCY == 1) begin : g_lat1
      logic w_unused_cap;
      assign w_unused_cap = ^{r_we, r_addr, r_wdata, r_be, r_cnt};
      assign w_enter_resp = w_accept;
      assign w_acc_we     = we_i;
      assign w_acc_addr   = addr_i[c_aw+1:0];
      assign w_acc_wdata  = wdata_i;
      assign w_acc_be     = be_i;
    end else begin : g_latn
      assign w_enter_resp = (r_state == S_WAIT) && (r_cnt == 4'd1);
      assign w_acc_we     = r_we;
      assign w_acc_addr   = r_addr;
      assign w_acc_wdata  = r_wdata;
      assign w_acc_be     = r_be;
    end
  endgenerate

  assign w_misaligned = |w_acc_addr[1:0];
  assign w_idx        = w_acc_addr[c_aw+1:2];

  // Control FSM with registered response outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i[c_aw+1:0];
            r_wdata <= wdata_i;
            r_be    <= be_i;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_wait_init;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // The request still asserted here is the one just served
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_resp) begin
        done_o <= 1'b1;
        err_o  <= w_misaligned;
        if (w_misaligned) begin
          rdata_o <= '0;
        end else if (!w_acc_we) begin
          rdata_o <= r_mem[w_idx];
        end
      end
    end
  end

  // Byte-masked store commit on the edge entering RESP; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_enter_resp && w_acc_we && !w_misaligned) begin
      for (int k = 0; k < 4; k++) begin
        if (w_acc_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_acc_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the data store; power of two.
REQ-002 Parameter LATENCY, default 3: cycles from request acceptance to response; legal range 1..15.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 req_i  input  1  MEM-stage access request; held stable by the pipeline while stall_o is high.
REQ-007 we_i  input  1  1 = store, 0 = load.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data.
REQ-010 be_i  input  4  store byte enables; be_i[k] selects wdata_i[8k+7:8k].
REQ-011 stall_o  output  1  freeze IF/ID/EX/MEM pipeline registers.
REQ-012 done_o  output  1  one-cycle response pulse.
REQ-013 rdata_o  output  32  load data, valid when done_o is high; holds its value otherwise.
REQ-014 err_o  output  1  one-cycle misalignment flag, coincident with done_o.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE with req_i=1 in cycle N, the block SHALL capture we_i, addr_i, wdata_i, be_i and enter WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-017 stall_o SHALL be combinational: high in cycle N (IDLE and req_i) and in every WAIT cycle; low in RESP and idle IDLE.
REQ-018 A down-counter SHALL keep WAIT for exactly LATENCY-1 cycles, so stall_o is high for cycles N..N+LATENCY-1.
REQ-019 RESP SHALL occur in cycle N+LATENCY with done_o=1, then return to IDLE unconditionally.
REQ-020 req_i SHALL be ignored in WAIT and RESP; the request still present during RESP is the same already-served access and SHALL NOT be re-issued.
REQ-021 Back-to-back requests SHALL be accepted no earlier than cycle N+LATENCY+1.
REQ-022 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits ignored (address wraps modulo DEPTH words).
REQ-023 Stores SHALL update only enabled bytes, committed at the clock edge entering RESP; be_i=0000 SHALL leave memory unchanged.
REQ-024 Loads SHALL register the full addressed word into rdata_o at the edge entering RESP.
REQ-025 If captured addr[1:0] != 00: no memory write, rdata_o SHALL be 0, err_o=1 during RESP.
REQ-026 A load following a store to the same word SHALL return the stored data (no stale read).
REQ-027 done_o and err_o SHALL never be high outside RESP.

Reset
REQ-028 Reset assertion SHALL force, asynchronously: state IDLE, counter 0, done_o 0, err_o 0, rdata_o 0.
REQ-029 stall_o SHALL be 0 while rst_n_i is low, regardless of req_i.
REQ-030 Reset mid-WAIT SHALL abandon the access; a store not yet committed SHALL NOT modify memory.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 After deassertion the first req_i=1 SHALL be accepted in the first rising edge with rst_n_i high.

Verification
REQ-033 Store/load: LATENCY=3, store 0xDEADBEEF to 0x10 be=1111, then load 0x10 -> stall_o high 3 cycles each, done_o at cycle N+3, rdata_o=0xDEADBEEF.
REQ-034 Byte enables: word at 0x20 = 0x11223344, store 0xAABBCCDD be=0101 then load -> rdata_o=0x11BB33DD.
REQ-035 Misaligned: load addr 0x22 -> err_o=1 and done_o=1 same cycle, rdata_o=0; store addr 0x21 leaves word 0x20 unchanged.
REQ-036 Hold request through RESP: req_i kept high for 6 cycles with LATENCY=3 -> exactly one done_o pulse for first access, second accepted at N+4, done_o at N+7.
REQ-037 Reset mid-WAIT: store 0x55 to 0x40 (old 0x0), assert rst_n_i in cycle N+1 -> all outputs 0, later load 0x40 returns 0x0.
REQ-038 Wrap and LATENCY=1: DEPTH=256, store 0x77 to 0x400, load 0x0 -> rdata_o=0x77; stall_o high for one cycle per access.
